// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer for the async FIFO: issues reads against a credit limit and
// buffers the one-cycle-latency read data into a valid/ready output stream.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             rd_clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_read_data,
  output logic                             fifo_read_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
  output logic [CNT_WIDTH-1:0]             xfer_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  wr_sel;

  logic [IDX_W-1:0]     rd_idx_reg, rd_idx_next;
  logic [IDX_W-1:0]     wr_idx_reg, wr_idx_next;
  logic [OCC_W-1:0]     occ_reg, occ_next;
  logic                 inflight_reg;
  logic [CNT_WIDTH-1:0] xfer_reg, xfer_next;

  logic                 pop;
  logic                 capture;
  logic [OCC_W:0]       credit_used;
  logic [OCC_W:0]       credit_limit;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  assign pop     = m_valid && m_ready;
  assign capture = inflight_reg;

  // A read is allowed only if every word already owed to the buffer, plus this
  // one, still fits after this cycle's pop; that is why m_ready feeds read_en.
  assign credit_used  = {1'b0, occ_reg} + {{OCC_W{1'b0}}, inflight_reg};
  assign credit_limit = (OCC_W + 1)'(BUF_DEPTH) + {{OCC_W{1'b0}}, pop};
  assign fifo_read_en = !reset && !fifo_empty && (credit_used < credit_limit);

  assign m_valid    = (occ_reg != '0);
  assign m_data     = buf_mem[rd_idx_reg];
  assign buf_count  = occ_reg;
  assign xfer_count = xfer_reg;

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = capture && (wr_idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    rd_idx_next = rd_idx_reg;
    wr_idx_next = wr_idx_reg;
    occ_next    = occ_reg;
    xfer_next   = xfer_reg;
    if (capture) begin
      wr_idx_next = idx_inc(wr_idx_reg);
    end
    if (pop) begin
      rd_idx_next = idx_inc(rd_idx_reg);
      xfer_next   = xfer_reg + 1'b1;
    end
    case ({capture, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  // Entries are cleared on reset so m_data reads as zero before the first word.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_sel[i]) begin
          buf_mem[i] <= fifo_read_data;
        end
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      rd_idx_reg   <= '0;
      wr_idx_reg   <= '0;
      occ_reg      <= '0;
      inflight_reg <= 1'b0;
      xfer_reg     <= '0;
    end else begin
      rd_idx_reg   <= rd_idx_next;
      wr_idx_reg   <= wr_idx_next;
      occ_reg      <= occ_next;
      inflight_reg <= fifo_read_en;
      xfer_reg     <= xfer_next;
    end
  end

endmodule
